// File: rtl/wos_filter_unit.sv
// wos_filter_unit -- execute-stage responder for the custom FILTER opcode.
//
// On i_run the unit stalls the pipeline. It loads an N-entry window of
// {weight, sample} words from data memory starting at the base address.
// It then computes the weighted order statistic: the smallest sample x_i
// whose cumulative weight S_i = sum(w_j : x_j <= x_i) reaches threshold T.
// If no sample reaches T, the result is max(x). The result is written to
// the destination address and the stall is released.
//
// Optional feature (macro WOS_FILTER_PERF_CNT_EN):
//   defined   -> o_op_count counts completed operations (wraps, rst clears)
//   undefined -> o_op_count tied to 0, no register built
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   i_run             FILTER instruction present in EX
//   i_reg1            [AW-1:0] source base word address
//   i_reg2            [15:0] destination word address, [31:16] threshold T
//   o_stall           hold IF/ID/EX
//   o_mem_rd_addr     registered read address
//   i_mem_rd_data     read data, 1-cycle latency; [DW-1:0] sample,
//                     [DW+WW-1:DW] weight
//   o_mem_wr_en/addr/data  one-cycle result write (zero-extended sample)
//   o_op_count        completed-operation counter

// One comparator lane: contributes w_j to S_i when x_j <= x_i.
module wos_filter_lane #(
  parameter int DW = 8,
  parameter int WW = 8
) (
  input  logic [DW-1:0] i_xj,
  input  logic [DW-1:0] i_xi,
  input  logic [WW-1:0] i_wj,
  output logic [WW-1:0] o_contrib
);
  assign o_contrib = (i_xj <= i_xi) ? i_wj : '0;
endmodule

module wos_filter_unit #(
  parameter int N  = 9,
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  input  logic [31:0]   i_reg1,
  input  logic [31:0]   i_reg2,
  output logic          o_stall,
  output logic [AW-1:0] o_mem_rd_addr,
  input  logic [31:0]   i_mem_rd_data,
  output logic          o_mem_wr_en,
  output logic [AW-1:0] o_mem_wr_addr,
  output logic [31:0]   o_mem_wr_data,
  output logic [31:0]   o_op_count
);

  localparam int CW   = $clog2(N + 1);
  localparam int SW   = WW + $clog2(N);
  localparam int TW   = 16;
  localparam int CMPW = (SW > TW) ? SW : TW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_STORE, S_DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] dst;
    logic [TW-1:0] thr;
  } req_t;

  state_t                   state_q, state_d;
  req_t                     req_q, req_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N-1:0][DW-1:0]     x_q, x_d;
  logic [N-1:0][WW-1:0]     w_q, w_d;
  logic [DW-1:0]            best_q, best_d;
  logic                     hit_q, hit_d;
  logic [DW-1:0]            max_q, max_d;
  logic [AW-1:0]            rd_addr_q, rd_addr_d;
  logic                     wr_en_q, wr_en_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;

  logic [DW-1:0]            x_i;
  logic [N-1:0][WW-1:0]     contrib;
  logic [SW-1:0]            sum;
  logic                     qual;

  // Upper operand/read-data bits carry nothing for this unit.
  logic unused_bits;
  assign unused_bits = ^{i_reg1[31:AW], i_mem_rd_data[31:DW+WW]};

  // Candidate under evaluation, selected by the EVAL index.
  always_comb begin
    x_i = '0;
    for (int j = 0; j < N; j++)
      if (cnt_q == CW'(j)) x_i = x_q[j];
  end

  // All N comparators run in parallel against the current candidate.
  for (genvar j = 0; j < N; j++) begin : g_lane
    wos_filter_lane #(.DW(DW), .WW(WW)) u_lane (
      .i_xj      (x_q[j]),
      .i_xi      (x_i),
      .i_wj      (w_q[j]),
      .o_contrib (contrib[j])
    );
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < N; j++) sum = sum + SW'(contrib[j]);
  end

  assign qual = CMPW'(sum) >= CMPW'(req_q.thr);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    w_d       = w_q;
    best_d    = best_q;
    hit_d     = hit_q;
    max_d     = max_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          req_d.base = i_reg1[AW-1:0];
          req_d.dst  = i_reg2[AW-1:0];
          req_d.thr  = i_reg2[31:16];
          rd_addr_d  = i_reg1[AW-1:0];
          cnt_d      = '0;
          best_d     = '0;
          hit_d      = 1'b0;
          max_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // Address for cycle k is presented during cycle k; its data
        // lands one cycle later and is captured as entry k.
        for (int j = 0; j < N; j++) begin
          if (cnt_q == CW'(j + 1)) begin
            x_d[j] = i_mem_rd_data[DW-1:0];
            w_d[j] = i_mem_rd_data[DW+WW-1:DW];
          end
        end
        if (cnt_q < CW'(N - 1)) rd_addr_d = rd_addr_q + 1'b1;
        if (cnt_q == CW'(N)) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        // Strict < keeps the first-found minimum on duplicate samples.
        if (qual && (!hit_q || x_i < best_q)) begin
          best_d = x_i;
          hit_d  = 1'b1;
        end
        if (x_i > max_q) max_d = x_i;
        if (cnt_q == CW'(N - 1)) begin
          // Register the write so it is presented during STORE.
          wr_en_d   = 1'b1;
          wr_addr_d = req_q.dst;
          wr_data_d = {{(32-DW){1'b0}}, (hit_d ? best_d : max_d)};
          cnt_d     = '0;
          state_d   = S_STORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      w_q       <= '0;
      best_q    <= '0;
      hit_q     <= 1'b0;
      max_q     <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      w_q       <= w_d;
      best_q    <= best_d;
      hit_q     <= hit_d;
      max_q     <= max_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The accept cycle stalls combinationally; rst gating keeps it low in reset.
  assign o_stall = rst & ((state_q == S_IDLE && i_run) || state_q == S_LOAD ||
                          state_q == S_EVAL || state_q == S_STORE);

  assign o_mem_rd_addr = rd_addr_q;
  assign o_mem_wr_en   = wr_en_q;
  assign o_mem_wr_addr = wr_addr_q;
  assign o_mem_wr_data = wr_data_q;

`ifdef WOS_FILTER_PERF_CNT_EN
  logic [31:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == S_STORE) op_count_d = op_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) op_count_q <= '0;
    else      op_count_q <= op_count_d;
  end

  assign o_op_count = op_count_q;
`else
  assign o_op_count = '0;
`endif

endmodule

// File: tb/tb_wos_filter_unit.sv
module tb_wos_filter_unit;
  localparam int N = 9, DW = 8, WW = 8, AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_run = 1'b0;
  logic [31:0]   i_reg1 = '0, i_reg2 = '0;
  logic          o_stall;
  logic [AW-1:0] o_mem_rd_addr;
  logic [31:0]   i_mem_rd_data = '0;
  logic          o_mem_wr_en;
  logic [AW-1:0] o_mem_wr_addr;
  logic [31:0]   o_mem_wr_data;
  logic [31:0]   o_op_count;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] mem [0:65535];

  wos_filter_unit #(.N(N), .DW(DW), .WW(WW), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_run         (i_run),
    .i_reg1        (i_reg1),
    .i_reg2        (i_reg2),
    .o_stall       (o_stall),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_op_count    (o_op_count)
  );

  always #5 clk = ~clk;

  // Synchronous 1-cycle-latency read port.
  always @(posedge clk) i_mem_rd_data <= mem[o_mem_rd_addr];

  // Monitor: every write strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst && o_mem_wr_en) begin
      wr_t e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", o_mem_wr_addr, o_mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (o_mem_wr_addr !== e.addr || o_mem_wr_data !== e.data) begin
          errors++;
          $display("FAIL write got addr=%h data=%0d expected addr=%h data=%0d",
                   o_mem_wr_addr, o_mem_wr_data, e.addr, e.data);
        end
        checks++;
        if (o_stall !== 1'b1) begin
          errors++;
          $display("FAIL write_in_stall got stall=%b expected 1", o_stall);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put_win(input logic [15:0] base, input logic [0:8][7:0] xs,
                         input logic [0:8][7:0] ws);
    for (int k = 0; k < N; k++) mem[base + 16'(k)] = {16'h0, ws[k], xs[k]};
  endtask

  // Counts consecutive stalled cycles starting at the current cycle.
  task automatic count_stall(output int n, input bit drop);
    n = 0;
    #1;
    while (o_stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      if (drop) begin
        i_run  = 1'b0;
        i_reg1 = 32'hDEAD_BEEF;
        i_reg2 = 32'h0BAD_F00D;
      end
      #1;
    end
  endtask

  task automatic do_op(input string name, input logic [15:0] base, input logic [15:0] dst,
                       input logic [15:0] thr, input logic [7:0] exp);
    int n, w0;
    exp_q.push_back('{dst, {24'h0, exp}});
    w0 = wr_cnt;
    @(negedge clk);
    i_run  = 1'b1;
    i_reg1 = {16'h0, base};
    i_reg2 = {thr, dst};
    count_stall(n, 1'b1);
    check({name, "_stall_len"}, n, 21);
    check({name, "_wr_count"}, wr_cnt - w0, 1);
    @(negedge clk);
  endtask

  logic [31:0] cnt_scale;
  int n1, n2, w0;

  initial begin
`ifdef WOS_FILTER_PERF_CNT_EN
    cnt_scale = 32'd1;
`else
    cnt_scale = 32'd0;
`endif
    put_win(16'h100, {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6},
                     {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1});
    put_win(16'h140, {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6},
                     {8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1});
    put_win(16'h180, {8'd4, 8'd4, 8'd4, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd9},
                     {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1});

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall",   {31'h0, o_stall}, 0);
    check("rst_rd_addr", {16'h0, o_mem_rd_addr}, 0);
    check("rst_wr_en",   {31'h0, o_mem_wr_en}, 0);
    check("rst_wr_addr", {16'h0, o_mem_wr_addr}, 0);
    check("rst_wr_data", o_mem_wr_data, 0);
    check("rst_op_count", o_op_count, 0);
    @(negedge clk);
    rst = 1'b1;

    do_op("median",   16'h100, 16'h200, 16'd5,  8'd5);
    do_op("wt_t6",    16'h140, 16'h201, 16'd6,  8'd6);
    do_op("wt_t7",    16'h140, 16'h202, 16'd7,  8'd7);
    do_op("wt_t0",    16'h140, 16'h203, 16'd0,  8'd1);
    do_op("wt_t12",   16'h140, 16'h204, 16'd12, 8'd9);
    do_op("dup_t3",   16'h180, 16'h205, 16'd3,  8'd4);
    #1;
    check("op_count_6", o_op_count, 6 * cnt_scale);

    // Reset during the 5th EVAL cycle: no write may follow.
    w0 = wr_cnt;
    @(negedge clk);
    i_run  = 1'b1;
    i_reg1 = 32'h100;
    i_reg2 = {16'd5, 16'h206};
    repeat (15) begin
      @(negedge clk);
      i_run = 1'b0;
    end
    #1;
    check("pre_rst_stall", {31'h0, o_stall}, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_stall", {31'h0, o_stall}, 0);
    check("mid_rst_wr_en", {31'h0, o_mem_wr_en}, 0);
    check("mid_rst_count", o_op_count, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("mid_rst_no_write", wr_cnt - w0, 0);

    do_op("recover", 16'h100, 16'h207, 16'd5, 8'd5);
    #1;
    check("op_count_1", o_op_count, cnt_scale);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back with i_run held high across the first DONE cycle.
    exp_q.push_back('{16'h208, 32'd5});
    exp_q.push_back('{16'h208, 32'd5});
    w0 = wr_cnt;
    @(negedge clk);
    i_run  = 1'b1;
    i_reg1 = 32'h100;
    i_reg2 = {16'd5, 16'h208};
    count_stall(n1, 1'b0);
    check("b2b_stall1", n1, 21);
    @(negedge clk);
    count_stall(n2, 1'b1);
    check("b2b_stall2", n2, 21);
    check("b2b_wr_count", wr_cnt - w0, 2);
    @(negedge clk);
    #1;
    check("b2b_op_count", o_op_count, 2 * cnt_scale);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule

// File: doc/wos_filter_unit.md
# wos_filter_unit

- Execute-side responder for the custom FILTER opcode (`0001011`).
- Accepts the pipeline's `run_filter` request with both register operands.
- Stalls the pipeline while it loads an N-sample window of sample/weight pairs from data memory and computes the weighted order statistic. It then writes the result back to memory and releases the stall.
- Sits beside the ALU in EX; owns a dedicated data-memory port that is used only while the pipeline is stalled.

## Interface
- N, 9: window length (samples per operation)
- DW, 8: sample width
- WW, 8: weight width
- AW, 16: word address width
- clk  in  1  clock
- rst  in  1  reset; rst asynchronous, active-low; clock clk
- i_run  in  1  FILTER instruction present in EX
- i_reg1  in  32  source base word address (`[AW-1:0]` used)
- i_reg2  in  32  `[15:0]` destination word address; `[31:16]` threshold T
- o_stall  out  1  hold IF/ID/EX
- o_mem_rd_addr  out  AW  read address
- i_mem_rd_data  in  32  read data, synchronous, 1-cycle latency; `[DW-1:0]` sample, `[DW+WW-1:DW]` weight
- o_mem_wr_en  out  1  write strobe
- o_mem_wr_addr  out  AW  write address
- o_mem_wr_data  out  32  result, zero-extended from DW
- o_op_count  out  32  completed-operation counter (see Configuration)

## Operation
- States: IDLE, LOAD, EVAL, STORE, DONE.
- **IDLE**
  - When i_run=1: latch the base address, destination address and T; set the read index to 0; go to LOAD.
- **LOAD** (N+1 cycles)
  - Cycles 0..N-1 issue reads of base+k.
  - Cycles 1..N capture x[k-1] and w[k-1] into the window registers.
  - After the last capture, go to EVAL.
- **EVAL** (N cycles, candidate i = 0..N-1)
  - Per cycle: S_i = Σ w_j over all j with x_j ≤ x_i. Evaluate all N comparators in parallel.
  - The sum is width WW+clog2(N), compared unsigned against T zero-extended.
  - If S_i ≥ T and (no hit yet, or x_i < best): best ← x_i and set the hit flag.
  - Track max(x) in parallel.
  - After i = N-1, go to STORE.
- **STORE** (1 cycle)
  - o_mem_wr_en=1, o_mem_wr_addr=dst, o_mem_wr_data = hit ? best : max(x).
  - Then go to DONE.
- **DONE** (1 cycle)
  - o_stall=0 so the FILTER instruction leaves EX.
  - i_run is ignored this cycle; go to IDLE.
- o_stall = (IDLE & i_run) | LOAD | EVAL | STORE.
- Boundary cases:
  - T=0: every candidate qualifies; the result is min(x).
  - T > Σw: no candidate qualifies; the result is max(x).
  - Duplicate samples: resolved by ≤, so the result is deterministic.
  - Zero weights are legal.
- Arithmetic is unsigned throughout.

## Timing
- Reset state: IDLE. All outputs reset to 0: o_stall, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_op_count. Window registers, best and hit are also cleared.
- Latency from the i_run accept cycle:
  - o_stall is high for 2N+3 consecutive cycles (21 for N=9).
  - The write strobe occurs in the last stalled cycle.
  - o_stall is low in the following (DONE) cycle.
- o_mem_rd_addr is registered, so the read data for address k is used two edges after the issue of k.
- o_mem_wr_en is high for exactly one cycle per operation.
- Operands are sampled only at the accept edge. Later changes on i_reg1/i_reg2 are ignored.
- Reset asserted mid-operation: immediate return to IDLE with outputs 0. No write is issued and the counter is cleared.
- Back-to-back FILTER instructions: the second is accepted no earlier than the cycle after DONE.

## Configuration
- Macro: `WOS_FILTER_PERF_CNT_EN`.
- Defined:
  - o_op_count increments by 1 in the STORE cycle.
  - It wraps at 2^32 and is cleared only by rst.
- Undefined:
  - No counter register is built; o_op_count is tied to 0.

## Test plan
- **Median window:** base 0x100 holds x={5,1,9,3,7,2,8,4,6}, w=1 each, T=5, dst 0x200 -> mem[0x200]=5; o_stall high exactly 21 cycles; one write strobe.
- **Weighted window:** same x, w[4]=3 (x=7), others 1.
  - T=6 -> 6.
  - T=7 -> 7.
- **Threshold extremes:** T=0 -> 1 (min); T=12 with Σw=11 -> 9 (max).
- **Duplicates:** x={4,4,4,1,1,9,9,9,9}, w=1, T=3 -> 4.
- **Reset mid-EVAL:** rst low during the 5th EVAL cycle -> o_stall=0 and o_mem_wr_en never asserted; the next i_run completes normally with the correct result.
- **Back-to-back and counter:** i_run held high across two FILTER ops -> two separate 21-cycle stalls with one DONE gap. With `WOS_FILTER_PERF_CNT_EN`, o_op_count=2; without it, o_op_count=0.
